// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus: instruction memory port, decode handshake and execute redirect.
// The master modport belongs to the fetch controller.
interface inst_fetch_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int PC_W   = 32
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_insn;
    logic [PC_W-1:0]   if_pc;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;

    modport master (
        output imem_addr, if_valid, if_insn, if_pc,
        input  imem_data, if_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_addr, if_valid, if_insn, if_pc,
        output imem_data, if_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, registers one instruction for decode,
// handles branch redirects and stops after the last program word.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | after reset, waiting for start
//   S_RUN   | fetching one word per cycle while decode keeps up
//   S_DRAIN | last word loaded, waiting for decode to take it
//   S_HALT  | program finished, start reruns it
//   S_ERR   | bad redirect target seen, stuck until reset
module inst_fetch_ctrl #(
    parameter int ADDR_W    = 5,
    parameter int PC_W      = 32,
    parameter int RESET_PC  = 0,
    parameter int LAST_WORD = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    inst_fetch_ctrl_if.master   bus,
    output logic                busy_o,
    output logic                halted_o,
    output logic                err_o
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_HALT  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [PC_W-1:0] RESET_PC_V  = PC_W'(RESET_PC);
    localparam logic [PC_W-3:0] LAST_WORD_V = (PC_W-2)'(LAST_WORD);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [31:0]       insn_q, insn_d;
    logic [PC_W-1:0]   ifpc_q, ifpc_d;

    logic              target_ok;
    logic              load;

    // A target must be word aligned and land inside the program image.
    assign target_ok = (bus.redirect_pc[1:0] == 2'b00) &&
                       (bus.redirect_pc[PC_W-1:2] <= LAST_WORD_V);
    assign load      = (state_q == S_RUN) && (!valid_q || bus.if_ready) && !bus.redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC_V;
            valid_q <= 1'b0;
            insn_q  <= '0;
            ifpc_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            insn_q  <= insn_d;
            ifpc_q  <= ifpc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        insn_d  = insn_q;
        ifpc_d  = ifpc_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start_i) begin
                    pc_d    = RESET_PC_V;
                    state_d = S_RUN;
                end
            end
            S_RUN, S_DRAIN: begin
                if (bus.redirect) begin
                    valid_d = 1'b0;
                    if (target_ok) begin
                        pc_d    = bus.redirect_pc;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (state_q == S_RUN) begin
                    if (load) begin
                        insn_d  = bus.imem_data;
                        ifpc_d  = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + PC_W'(4);
                        if (pc_q[PC_W-1:2] == LAST_WORD_V) begin
                            state_d = S_DRAIN;
                        end
                    end
                end else if (!valid_q || bus.if_ready) begin
                    valid_d = 1'b0;
                    state_d = S_HALT;
                end
            end
            S_ERR: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = S_ERR;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.imem_addr = pc_q[ADDR_W+1:2];
    assign bus.if_valid  = valid_q;
    assign bus.if_insn   = insn_q;
    assign bus.if_pc     = ifpc_q;
    assign busy_o        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign halted_o      = (state_q == S_HALT);
    assign err_o         = (state_q == S_ERR);
endmodule
